fetch_stage: RTL and testbench
==============================

// Module: fetch_stage
// PURPOSE
//   Fetch stage of the pipelined core: owns PCF, issues one request at a time to a
//   variable-latency instruction memory and fills the IF/ID register (InstrD/PCD/PCPlus4D/ValidD).
//   Consumes the execute-stage redirect PCSrcE (00 seq, 01 PC-relative target, 10 JALR target)
//   plus StallF/StallD from the hazard unit. Stale in-flight responses are discarded.
// PARAMETERS
//   XLEN      32            data/address width
//   RESET_PC  32'h00000000  PCF value after reset
// PORTS
//   clk         in   1     clock; all state updates on rising edge
//   rst         in   1     synchronous reset, active-high
//   PCSrcE      in   2     redirect select from execute stage
//   PCTargetE   in   XLEN  branch/JAL target (PCSrcE=01)
//   ALUResultE  in   XLEN  JALR target before LSB clear (PCSrcE=10)
//   StallF      in   1     inhibit issuing a new fetch
//   StallD      in   1     hold IF/ID register contents
//   imem_req    out  1     one-cycle request pulse
//   imem_addr   out  XLEN  request address (= PCF while imem_req)
//   imem_rvalid in   1     response valid, >=1 cycle after request
//   imem_rdata  in   32    response instruction word
//   PCF         out  XLEN  current fetch PC
//   InstrD      out  32    IF/ID instruction
//   PCD         out  XLEN  IF/ID PC
//   PCPlus4D    out  XLEN  IF/ID PC+4
//   ValidD      out  1     IF/ID holds a real instruction
// BEHAVIOUR
//   Reset (rst=1 at edge): state=IDLE, PCF=RESET_PC, ValidD=0, InstrD=32'h00000013, PCD=0,
//     PCPlus4D=0, buffer empty; imem_req=0 whenever rst=1.
//   redirect = (PCSrcE!=00). Target: 01 -> PCTargetE; 10 -> ALUResultE & ~1; 11 treated as 00.
//   Redirect has priority over StallF/StallD: PCF<=target, ValidD<=0 next cycle, buffer dropped.
//   At most one outstanding request. Min 2 cycles per instruction (blocking fetch).
//   FSM:
//     IDLE    : redirect -> PCF<=target, stay IDLE, no req. Else !StallF -> imem_req=1,
//               imem_addr=PCF, -> WAIT. Else stay.
//     WAIT    : redirect & rvalid -> drop response, -> IDLE. redirect & !rvalid -> DISCARD.
//               rvalid & !StallD -> IF/ID <= {rdata, PCF, PCF+4, 1}, PCF<=PCF+4, -> IDLE.
//               rvalid & StallD -> buffer {rdata, PCF} -> BUFFER.
//     DISCARD : redirect -> PCF<=target, stay. rvalid -> drop response, -> IDLE.
//     BUFFER  : redirect -> drop buffer -> IDLE. !StallD -> IF/ID <= buffer (ValidD=1),
//               PCF<=PCF+4, -> IDLE.
//   IF/ID when not loaded this cycle: StallD & !redirect -> hold; else ValidD<=0 (bubble),
//     InstrD/PCD/PCPlus4D unchanged.
//   PCF+4 and targets wrap modulo 2^XLEN; no alignment check beyond JALR LSB clear.
//   imem_rvalid in IDLE/BUFFER is a protocol error: ignored.
//   rst mid-operation: return to reset values; a response arriving after rst deasserts,
//     while in IDLE, is ignored.
// TESTING
//   Reset release, StallF=StallD=0, 1-cycle memory returning 0xA..: req addr 0,4,8 on
//     alternating cycles; InstrD/PCD follow, ValidD pulses 1 every 2nd cycle.
//   PCSrcE=01, PCTargetE=0x100 while WAIT, rvalid 2 cycles later: response dropped (ValidD
//     stays 0), next req addr=0x100.
//   PCSrcE=10, ALUResultE=0x205 in IDLE -> PCF=0x204; next req addr=0x204.
//   rvalid with StallD=1 for 3 cycles: IF/ID held, no new req; StallD falls -> buffered instr
//     appears in InstrD next edge, PCF+=4.
//   Redirect same cycle as rvalid and StallD=1: response dropped, ValidD=0, PCF=target.
//   rst asserted in WAIT: next edge PCF=RESET_PC, ValidD=0, InstrD=0x13; late rvalid ignored.

Source files
------------

// File: rtl/fetch_stage_if.sv
// ---------------------------------------------------------------------------
// fetch_stage_if
//   Instruction-memory request/response bus between the fetch stage and a
//   variable-latency instruction memory. One request is a single-cycle pulse
//   on imem_req carrying imem_addr; the memory answers one or more cycles
//   later with a single-cycle imem_rvalid pulse carrying imem_rdata.
//
//   Signals
//     imem_req     fetch -> mem   1     request pulse
//     imem_addr    fetch -> mem   XLEN  request address
//     imem_rvalid  mem -> fetch   1     response valid
//     imem_rdata   mem -> fetch   32    response instruction word
//
//   Modports
//     master : fetch stage side (drives req/addr)
//     slave  : memory side (drives rvalid/rdata)
// ---------------------------------------------------------------------------
interface fetch_stage_if #(
  parameter int XLEN = 32
);
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_rvalid;
  logic [31:0]     imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_rvalid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_rvalid,
    output imem_rdata
  );
endinterface

// File: rtl/fetch_stage.sv
// ---------------------------------------------------------------------------
// fetch_stage
//   Fetch stage of the pipelined core. Owns the fetch PC (PCF), issues at most
//   one outstanding request to a variable-latency instruction memory and fills
//   the IF/ID pipeline register (InstrD/PCD/PCPlus4D/ValidD). Fetch is
//   blocking, so the stage needs at least two cycles per instruction.
//
//   Redirects from execute (PCSrcE) take priority over both stalls: PCF jumps
//   to the target, the IF/ID register turns into a bubble, any buffered
//   instruction is dropped, and a response already in flight is discarded
//   when it eventually arrives.
//
//   Ports
//     clk         in   1     clock, rising edge
//     rst         in   1     synchronous reset, active-high
//     PCSrcE      in   2     00 sequential, 01 PC-relative, 10 JALR, 11 = 00
//     PCTargetE   in   XLEN  branch/JAL target
//     ALUResultE  in   XLEN  JALR target (bit 0 cleared here)
//     StallF      in   1     do not issue a new fetch
//     StallD      in   1     hold the IF/ID register
//     imem        master    instruction-memory bus (fetch_stage_if)
//     PCF         out  XLEN  current fetch PC
//     InstrD      out  32    IF/ID instruction
//     PCD         out  XLEN  IF/ID PC
//     PCPlus4D    out  XLEN  IF/ID PC+4
//     ValidD      out  1     IF/ID holds a real instruction
// ---------------------------------------------------------------------------
module fetch_stage #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [1:0]      PCSrcE,
  input  logic [XLEN-1:0] PCTargetE,
  input  logic [XLEN-1:0] ALUResultE,
  input  logic            StallF,
  input  logic            StallD,
  fetch_stage_if.master   imem,
  output logic [XLEN-1:0] PCF,
  output logic [31:0]     InstrD,
  output logic [XLEN-1:0] PCD,
  output logic [XLEN-1:0] PCPlus4D,
  output logic            ValidD
);

  // addi x0, x0, 0 -- what a bubble decodes as
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  localparam logic [1:0] ST_IDLE    = 2'd0;  // ready to issue
  localparam logic [1:0] ST_WAIT    = 2'd1;  // request outstanding
  localparam logic [1:0] ST_DISCARD = 2'd2;  // outstanding request is stale
  localparam logic [1:0] ST_BUFFER  = 2'd3;  // response parked behind StallD

  logic [1:0]      state_reg, state_next;
  logic [XLEN-1:0] pc_reg, pc_next;

  logic [31:0]     instr_d_reg, instr_d_next;
  logic [XLEN-1:0] pc_d_reg, pc_d_next;
  logic [XLEN-1:0] pc_plus4_d_reg, pc_plus4_d_next;
  logic            valid_d_reg, valid_d_next;

  logic [31:0]     buf_instr_reg, buf_instr_next;
  logic [XLEN-1:0] buf_pc_reg, buf_pc_next;

  logic            redirect;
  logic [XLEN-1:0] target;
  logic [XLEN-1:0] pc_plus4;
  logic            load_fetch;   // IF/ID <= live response
  logic            load_buf;     // IF/ID <= buffered response
  logic            capture_buf;  // park live response in the buffer

  // -------------------------------------------------------------------------
  // Redirect decode. Encoding 11 is not a redirect.
  // -------------------------------------------------------------------------
  always_comb begin
    redirect = 1'b0;
    target   = pc_reg;
    case (PCSrcE)
      2'b01: begin
        redirect = 1'b1;
        target   = PCTargetE;
      end
      2'b10: begin
        redirect = 1'b1;
        target   = ALUResultE & ~XLEN'(1);
      end
      default: begin
        redirect = 1'b0;
        target   = pc_reg;
      end
    endcase
  end

  assign pc_plus4 = pc_reg + XLEN'(4);

  // -------------------------------------------------------------------------
  // Request issue: only from IDLE, never in the cycle a redirect arrives
  // (the address would already be stale) and never during reset.
  // -------------------------------------------------------------------------
  assign imem.imem_req  = !rst && (state_reg == ST_IDLE) && !redirect && !StallF;
  assign imem.imem_addr = pc_reg;

  // -------------------------------------------------------------------------
  // FSM and PC update. PCF stays on the address of the outstanding or
  // buffered instruction until that instruction is delivered into IF/ID,
  // so the response PC is always pc_reg.
  // -------------------------------------------------------------------------
  always_comb begin
    state_next     = state_reg;
    pc_next        = pc_reg;
    load_fetch     = 1'b0;
    load_buf       = 1'b0;
    capture_buf    = 1'b0;
    buf_instr_next = buf_instr_reg;
    buf_pc_next    = buf_pc_reg;

    case (state_reg)
      ST_IDLE: begin
        // imem_rvalid here is a protocol error and is ignored.
        if (redirect) begin
          pc_next = target;
        end else if (!StallF) begin
          state_next = ST_WAIT;
        end
      end

      ST_WAIT: begin
        if (redirect) begin
          pc_next    = target;
          // A response arriving with the redirect is simply dropped;
          // otherwise remember that the one still in flight is stale.
          state_next = imem.imem_rvalid ? ST_IDLE : ST_DISCARD;
        end else if (imem.imem_rvalid) begin
          if (!StallD) begin
            load_fetch = 1'b1;
            pc_next    = pc_plus4;
            state_next = ST_IDLE;
          end else begin
            capture_buf = 1'b1;
            state_next  = ST_BUFFER;
          end
        end
      end

      ST_DISCARD: begin
        if (redirect) begin
          pc_next = target;
        end
        // Leave as soon as the stale response has been swallowed, even if a
        // further redirect lands in the same cycle; waiting longer would
        // block on a response that will never come.
        if (imem.imem_rvalid) begin
          state_next = ST_IDLE;
        end
      end

      ST_BUFFER: begin
        // imem_rvalid here is a protocol error and is ignored.
        if (redirect) begin
          pc_next    = target;
          state_next = ST_IDLE;
        end else if (!StallD) begin
          load_buf   = 1'b1;
          pc_next    = pc_plus4;
          state_next = ST_IDLE;
        end
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase

    if (capture_buf) begin
      buf_instr_next = imem.imem_rdata;
      buf_pc_next    = pc_reg;
    end
  end

  // -------------------------------------------------------------------------
  // IF/ID register. When nothing is loaded: hold under StallD, otherwise
  // insert a bubble (ValidD=0) but leave the payload fields untouched.
  // -------------------------------------------------------------------------
  always_comb begin
    instr_d_next    = instr_d_reg;
    pc_d_next       = pc_d_reg;
    pc_plus4_d_next = pc_plus4_d_reg;
    valid_d_next    = valid_d_reg;

    if (load_fetch) begin
      instr_d_next    = imem.imem_rdata;
      pc_d_next       = pc_reg;
      pc_plus4_d_next = pc_plus4;
      valid_d_next    = 1'b1;
    end else if (load_buf) begin
      instr_d_next    = buf_instr_reg;
      pc_d_next       = buf_pc_reg;
      pc_plus4_d_next = buf_pc_reg + XLEN'(4);
      valid_d_next    = 1'b1;
    end else if (StallD && !redirect) begin
      valid_d_next    = valid_d_reg;
    end else begin
      valid_d_next    = 1'b0;
    end
  end

  // -------------------------------------------------------------------------
  // State registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= ST_IDLE;
      pc_reg         <= RESET_PC;
      instr_d_reg    <= NOP_INSTR;
      pc_d_reg       <= '0;
      pc_plus4_d_reg <= '0;
      valid_d_reg    <= 1'b0;
      buf_instr_reg  <= NOP_INSTR;
      buf_pc_reg     <= '0;
    end else begin
      state_reg      <= state_next;
      pc_reg         <= pc_next;
      instr_d_reg    <= instr_d_next;
      pc_d_reg       <= pc_d_next;
      pc_plus4_d_reg <= pc_plus4_d_next;
      valid_d_reg    <= valid_d_next;
      buf_instr_reg  <= buf_instr_next;
      buf_pc_reg     <= buf_pc_next;
    end
  end

  assign PCF      = pc_reg;
  assign InstrD   = instr_d_reg;
  assign PCD      = pc_d_reg;
  assign PCPlus4D = pc_plus4_d_reg;
  assign ValidD   = valid_d_reg;

endmodule

// File: tb/tb_fetch_stage.sv
// ---------------------------------------------------------------------------
// tb_fetch_stage
//   Directed bench for fetch_stage. Inputs change 1 time unit after each
//   rising edge; outputs are sampled at that same point, i.e. they reflect
//   the state after the edge plus the freshly driven inputs.
// ---------------------------------------------------------------------------
module tb_fetch_stage;

  logic        clk;
  logic        rst;
  logic [1:0]  PCSrcE;
  logic [31:0] PCTargetE;
  logic [31:0] ALUResultE;
  logic        StallF;
  logic        StallD;
  logic [31:0] PCF;
  logic [31:0] InstrD;
  logic [31:0] PCD;
  logic [31:0] PCPlus4D;
  logic        ValidD;

  int n_vec = 0;
  int n_err = 0;

  fetch_stage_if #(.XLEN(32)) imem_bus ();

  fetch_stage #(
    .XLEN    (32),
    .RESET_PC(32'h0000_0000)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .PCSrcE    (PCSrcE),
    .PCTargetE (PCTargetE),
    .ALUResultE(ALUResultE),
    .StallF    (StallF),
    .StallD    (StallD),
    .imem      (imem_bus.master),
    .PCF       (PCF),
    .InstrD    (InstrD),
    .PCD       (PCD),
    .PCPlus4D  (PCPlus4D),
    .ValidD    (ValidD)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    rst                  = 1'b1;
    PCSrcE               = 2'b00;
    PCTargetE            = '0;
    ALUResultE           = '0;
    StallF               = 1'b0;
    StallD               = 1'b0;
    imem_bus.imem_rvalid = 1'b0;
    imem_bus.imem_rdata  = '0;

    // ---------------- reset ----------------
    step();
    step();
    chk("rst_pcf",    PCF, 32'h0);
    chk("rst_valid",  {31'b0, ValidD}, 32'h0);
    chk("rst_instr",  InstrD, 32'h0000_0013);
    chk("rst_pcd",    PCD, 32'h0);
    chk("rst_pcp4d",  PCPlus4D, 32'h0);
    chk("rst_req",    {31'b0, imem_bus.imem_req}, 32'h0);
    rst = 1'b0;
    #1;
    $display("reset released: PCF=%h ValidD=%b InstrD=%h", PCF, ValidD, InstrD);

    // ---------------- sequential fetch, 1-cycle memory ----------------
    for (int i = 0; i < 3; i++) begin
      chk("seq_req",  {31'b0, imem_bus.imem_req}, 32'h1);
      chk("seq_addr", imem_bus.imem_addr, 32'(4 * i));
      step();
      chk("seq_valid_bubble", {31'b0, ValidD}, 32'h0);
      imem_bus.imem_rvalid = 1'b1;
      imem_bus.imem_rdata  = 32'hA000_0000 + 32'(i);
      #1;
      chk("seq_noreq", {31'b0, imem_bus.imem_req}, 32'h0);
      step();
      imem_bus.imem_rvalid = 1'b0;
      chk("seq_valid", {31'b0, ValidD}, 32'h1);
      chk("seq_instr", InstrD, 32'hA000_0000 + 32'(i));
      chk("seq_pcd",   PCD, 32'(4 * i));
      chk("seq_pcp4d", PCPlus4D, 32'(4 * i + 4));
      chk("seq_pcf",   PCF, 32'(4 * i + 4));
      $display("seq fetch %0d: PCD=%h InstrD=%h ValidD=%b", i, PCD, InstrD, ValidD);
    end

    // ---------------- PC-relative redirect while WAIT ----------------
    step();                                   // req 0x0C -> WAIT
    PCSrcE    = 2'b01;
    PCTargetE = 32'h0000_0100;
    #1;
    chk("br_noreq", {31'b0, imem_bus.imem_req}, 32'h0);
    step();                                   // -> DISCARD
    PCSrcE = 2'b00;
    #1;
    chk("br_pcf",   PCF, 32'h100);
    chk("br_valid", {31'b0, ValidD}, 32'h0);
    chk("br_discard_noreq", {31'b0, imem_bus.imem_req}, 32'h0);
    imem_bus.imem_rvalid = 1'b1;
    imem_bus.imem_rdata  = 32'hDEAD_BEEF;
    step();                                   // stale response dropped
    imem_bus.imem_rvalid = 1'b0;
    #1;
    chk("br_drop_valid", {31'b0, ValidD}, 32'h0);
    chk("br_drop_instr", InstrD, 32'hA000_0002);
    chk("br_req",   {31'b0, imem_bus.imem_req}, 32'h1);
    chk("br_addr",  imem_bus.imem_addr, 32'h100);
    $display("branch redirect: PCF=%h next req addr=%h", PCF, imem_bus.imem_addr);

    // ---------------- JALR redirect in IDLE ----------------
    PCSrcE     = 2'b10;
    ALUResultE = 32'h0000_0205;
    #1;
    chk("jalr_noreq", {31'b0, imem_bus.imem_req}, 32'h0);
    step();
    PCSrcE = 2'b00;
    #1;
    chk("jalr_pcf",  PCF, 32'h204);
    chk("jalr_req",  {31'b0, imem_bus.imem_req}, 32'h1);
    chk("jalr_addr", imem_bus.imem_addr, 32'h204);
    $display("jalr redirect: PCF=%h", PCF);

    // ---------------- response under StallD, 3 cycles ----------------
    step();                                   // -> WAIT
    StallD               = 1'b1;
    imem_bus.imem_rvalid = 1'b1;
    imem_bus.imem_rdata  = 32'hB000_0204;
    step();                                   // -> BUFFER
    imem_bus.imem_rvalid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("stall_instr", InstrD, 32'hA000_0002);
      chk("stall_valid", {31'b0, ValidD}, 32'h0);
      chk("stall_pcf",   PCF, 32'h204);
      chk("stall_noreq", {31'b0, imem_bus.imem_req}, 32'h0);
      if (k < 2) step();
    end
    StallD = 1'b0;
    step();
    chk("unstall_instr", InstrD, 32'hB000_0204);
    chk("unstall_pcd",   PCD, 32'h204);
    chk("unstall_pcp4d", PCPlus4D, 32'h208);
    chk("unstall_valid", {31'b0, ValidD}, 32'h1);
    chk("unstall_pcf",   PCF, 32'h208);
    $display("buffered instr delivered: InstrD=%h PCD=%h", InstrD, PCD);

    // ---------------- redirect + rvalid + StallD same cycle ----------------
    step();                                   // req 0x208 -> WAIT
    StallD               = 1'b1;
    imem_bus.imem_rvalid = 1'b1;
    imem_bus.imem_rdata  = 32'hC000_0208;
    PCSrcE               = 2'b01;
    PCTargetE            = 32'h0000_0300;
    step();
    imem_bus.imem_rvalid = 1'b0;
    PCSrcE               = 2'b00;
    StallD               = 1'b0;
    #1;
    chk("rdr_valid", {31'b0, ValidD}, 32'h0);
    chk("rdr_instr", InstrD, 32'hB000_0204);
    chk("rdr_pcf",   PCF, 32'h300);
    chk("rdr_addr",  imem_bus.imem_addr, 32'h300);
    $display("redirect over stalled response: PCF=%h ValidD=%b", PCF, ValidD);

    // ---------------- StallF and PCSrcE=11 ----------------
    StallF = 1'b1;
    PCSrcE = 2'b11;
    PCTargetE = 32'h0000_0500;
    #1;
    chk("stallf_noreq", {31'b0, imem_bus.imem_req}, 32'h0);
    step();
    chk("src11_pcf", PCF, 32'h300);
    PCSrcE = 2'b00;
    StallF = 1'b0;
    #1;
    chk("stallf_release_req", {31'b0, imem_bus.imem_req}, 32'h1);
    $display("StallF / PCSrcE=11: PCF=%h", PCF);

    // ---------------- reset in WAIT, late response ----------------
    step();                                   // -> WAIT
    rst = 1'b1;
    #1;
    chk("rstw_noreq", {31'b0, imem_bus.imem_req}, 32'h0);
    step();
    rst                  = 1'b0;
    StallF               = 1'b1;
    imem_bus.imem_rvalid = 1'b1;
    imem_bus.imem_rdata  = 32'hDEAD_0000;
    #1;
    chk("rstw_pcf",   PCF, 32'h0);
    chk("rstw_valid", {31'b0, ValidD}, 32'h0);
    chk("rstw_instr", InstrD, 32'h0000_0013);
    step();
    imem_bus.imem_rvalid = 1'b0;
    chk("late_valid", {31'b0, ValidD}, 32'h0);
    chk("late_instr", InstrD, 32'h0000_0013);
    chk("late_pcf",   PCF, 32'h0);
    $display("reset in WAIT: PCF=%h InstrD=%h", PCF, InstrD);

    // ---------------- PC wrap at top of address space ----------------
    PCSrcE    = 2'b01;
    PCTargetE = 32'hFFFF_FFFC;
    step();
    PCSrcE = 2'b00;
    StallF = 1'b0;
    #1;
    chk("wrap_addr", imem_bus.imem_addr, 32'hFFFF_FFFC);
    step();
    imem_bus.imem_rvalid = 1'b1;
    imem_bus.imem_rdata  = 32'hE000_0000;
    step();
    imem_bus.imem_rvalid = 1'b0;
    chk("wrap_pcd",   PCD, 32'hFFFF_FFFC);
    chk("wrap_pcp4d", PCPlus4D, 32'h0);
    chk("wrap_pcf",   PCF, 32'h0);
    chk("wrap_instr", InstrD, 32'hE000_0000);
    $display("wrap fetch: PCD=%h PCPlus4D=%h PCF=%h", PCD, PCPlus4D, PCF);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
